// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the pipeline MEM stage, the loader/debug requester and the data memory.
// The arbiter uses the slave modport; the surrounding environment uses master.
interface dmem_arbiter_if;
   logic        p_req;
   logic [31:0] p_addr;
   logic [31:0] p_wdata;
   logic [3:0]  p_we;
   logic [31:0] p_rdata;
   logic        p_stall;

   logic        l_req;
   logic [31:0] l_addr;
   logic [31:0] l_wdata;
   logic [3:0]  l_we;
   logic        l_ack;
   logic [31:0] l_rdata;

   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  we;
   logic [31:0] drdata;

   modport slave (
      input  p_req, p_addr, p_wdata, p_we, l_req, l_addr, l_wdata, l_we, drdata,
      output p_rdata, p_stall, l_ack, l_rdata, daddr, dwdata, we
   );

   modport master (
      output p_req, p_addr, p_wdata, p_we, l_req, l_addr, l_wdata, l_we, drdata,
      input  p_rdata, p_stall, l_ack, l_rdata, daddr, dwdata, we
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: pipeline has priority, loader gets a bounded-starvation slot.
// Optional DMEM_ARB_STATS_EN adds saturating stall_count/grant_count outputs.
module dmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               reset,
   dmem_arbiter_if.slave      bus
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]        stall_count,
   output logic [15:0]        grant_count
`endif
);

   typedef enum logic [1:0] {
      ARB,
      L_ACC,
      L_ACK
   } state_t;

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   state_t      state;
   state_t      state_next;
   logic        grant;
   logic [7:0]  starve_cnt;
   logic        l_ack_q;
   logic [31:0] l_rdata_q;

   always_ff @(posedge clk) begin
      if (reset) state <= ARB;
      else       state <= state_next;
   end

   // Loader owns the port only in L_ACC; reset kills any write and the stall in that cycle.
   always_comb begin
      state_next  = state;
      grant       = 1'b0;
      bus.daddr   = bus.p_addr;
      bus.dwdata  = bus.p_wdata;
      bus.we      = bus.p_req ? bus.p_we : 4'b0000;
      bus.p_stall = 1'b0;
      case (state)
         ARB: begin
            if (bus.l_req && (!bus.p_req || starve_cnt == LIMIT)) begin
               grant      = 1'b1;
               state_next = L_ACC;
            end
         end
         L_ACC: begin
            state_next  = L_ACK;
            bus.daddr   = bus.l_addr;
            bus.dwdata  = bus.l_wdata;
            bus.we      = bus.l_we;
            bus.p_stall = bus.p_req;
         end
         L_ACK:   state_next = ARB;
         default: state_next = ARB;
      endcase
      if (reset) begin
         bus.we      = 4'b0000;
         bus.p_stall = 1'b0;
      end
   end

   // Counts contended denials; a withdrawn request leaves the count where it was.
   always_ff @(posedge clk) begin
      if (reset)
         starve_cnt <= 8'd0;
      else if (grant)
         starve_cnt <= 8'd0;
      else if (state == ARB && bus.l_req && bus.p_req && starve_cnt < LIMIT)
         starve_cnt <= starve_cnt + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         l_ack_q   <= 1'b0;
         l_rdata_q <= 32'd0;
      end else begin
         l_ack_q <= (state == L_ACC);
         if (state == L_ACC) l_rdata_q <= bus.drdata;
      end
   end

   assign bus.p_rdata = bus.drdata;
   assign bus.l_ack   = l_ack_q;
   assign bus.l_rdata = l_rdata_q;

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= 16'd0;
         grant_count <= 16'd0;
      end else begin
         if (bus.p_stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
         if (grant && grant_count != 16'hFFFF)       grant_count <= grant_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// compared against a timestamp-based reference model of the arbitration rules.
module tb_dmem_arbiter;

   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic reset;
   logic mem_load;

   always #5 clk = ~clk;

   dmem_arbiter_if bus ();

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stall_count;
   logic [15:0] grant_count;
`endif

   dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stall_count (stall_count),
      .grant_count (grant_count)
`endif
   );

   // Behavioural data memory: combinational read, byte-enabled write on the clock edge.
   logic [31:0] mem [0:255];

   assign bus.drdata = mem[bus.daddr[9:2]];

   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 256; i++) mem[i] <= (32'(i) * 32'h01010101) ^ 32'hA5000000;
         mem[16] <= 32'hDEADBEEF;
         mem[48] <= 32'h5A5A5A5A;
      end else begin
         for (int b = 0; b < 4; b++)
            if (bus.we[b]) mem[bus.daddr[9:2]][8*b +: 8] <= bus.dwdata[8*b +: 8];
      end
   end

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model: a loader grant at cycle t means the access happens at t+1 and
   // the ack at t+2; everything else is pipeline-owned arbitration time.
   int          cyc         = 0;
   int          m_denied    = 0;
   int          m_acc_at    = -1;
   int          m_ack_at    = -1;
   logic [31:0] m_lrdata    = 32'd0;
   bit          model_valid = 1'b0;
   int          m_grants    = 0;
   int          m_stalls    = 0;

   bit          obs_ack;
   bit          obs_stall;
   logic [3:0]  obs_we;
   logic [31:0] obs_daddr;
   logic [31:0] obs_dwdata;
   logic [31:0] obs_lrdata;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, actual, expected);
      end
   endtask

   // Holds the current input values for one cycle, checks outputs mid-cycle, advances the model.
   task automatic applyStimulus();
      bit          owns;
      bit          free;
      logic [31:0] exp_daddr;
      logic [31:0] exp_dwdata;
      logic [3:0]  exp_we;
      bit          exp_stall;
      @(negedge clk);
      owns       = (cyc == m_acc_at);
      free       = !owns && (cyc != m_ack_at);
      exp_daddr  = owns ? bus.l_addr  : bus.p_addr;
      exp_dwdata = owns ? bus.l_wdata : bus.p_wdata;
      exp_we     = reset ? 4'b0000 : (owns ? bus.l_we : (bus.p_req ? bus.p_we : 4'b0000));
      exp_stall  = owns && bus.p_req && !reset;

      checkOutput("we", 32'(bus.we), 32'(exp_we));
      checkOutput("p_stall", 32'(bus.p_stall), 32'(exp_stall));
      if (model_valid) begin
         checkOutput("daddr", bus.daddr, exp_daddr);
         checkOutput("dwdata", bus.dwdata, exp_dwdata);
         checkOutput("p_rdata", bus.p_rdata, mem[exp_daddr[9:2]]);
         checkOutput("l_ack", 32'(bus.l_ack), 32'(cyc == m_ack_at));
         checkOutput("l_rdata", bus.l_rdata, m_lrdata);
      end

      obs_ack    = bus.l_ack;
      obs_stall  = bus.p_stall;
      obs_we     = bus.we;
      obs_daddr  = bus.daddr;
      obs_dwdata = bus.dwdata;
      obs_lrdata = bus.l_rdata;

      if (reset) begin
         m_denied    = 0;
         m_acc_at    = -1;
         m_ack_at    = -1;
         m_lrdata    = 32'd0;
         m_grants    = 0;
         m_stalls    = 0;
         model_valid = 1'b1;
      end else begin
         if (exp_stall) m_stalls++;
         if (owns) begin
            m_lrdata = mem[bus.l_addr[9:2]];
            m_ack_at = cyc + 1;
         end
         if (free && bus.l_req) begin
            if (!bus.p_req || m_denied == LIMIT) begin
               m_acc_at = cyc + 1;
               m_denied = 0;
               m_grants++;
            end else if (m_denied < LIMIT) begin
               m_denied++;
            end
         end
      end

      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic newLoaderRequest();
      bus.l_req   = 1'b1;
      bus.l_addr  = 32'($urandom_range(0, 255)) << 2;
      bus.l_wdata = $urandom;
      bus.l_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
   endtask

   initial begin : main
      int  stall_cyc;
      int  ack_cyc;
      bit  saw_stall;
      bit  prev_stall;
      int  acks;

      bus.p_req   = 1'b1;
      bus.p_addr  = 32'h0;
      bus.p_wdata = 32'h0;
      bus.p_we    = 4'b1111;
      bus.l_req   = 1'b0;
      bus.l_addr  = 32'h0;
      bus.l_wdata = 32'h0;
      bus.l_we    = 4'b0000;
      reset       = 1'b1;
      mem_load    = 1'b1;

      // Reset held two cycles with a pipeline store pending.
      applyStimulus();
      applyStimulus();
      checkOutput("reset_l_ack", 32'(obs_ack), 32'd0);
      checkOutput("reset_we", 32'(obs_we), 32'd0);
      reset    = 1'b0;
      mem_load = 1'b0;

      // Idle loader read.
      bus.p_req  = 1'b0;
      bus.p_we   = 4'b0000;
      bus.l_req  = 1'b1;
      bus.l_addr = 32'h40;
      bus.l_we   = 4'b0000;
      applyStimulus();
      applyStimulus();
      checkOutput("idle_daddr", obs_daddr, 32'h40);
      applyStimulus();
      checkOutput("idle_ack", 32'(obs_ack), 32'd1);
      checkOutput("idle_rdata", obs_lrdata, 32'hDEADBEEF);
      bus.l_req = 1'b0;

      // Starvation under continuous pipeline traffic.
      bus.p_req  = 1'b1;
      bus.p_addr = 32'h10;
      bus.l_req  = 1'b1;
      bus.l_addr = 32'h44;
      stall_cyc  = -1;
      ack_cyc    = -1;
      for (int c = 0; c < 12; c++) begin
         applyStimulus();
         if (obs_stall && stall_cyc < 0) stall_cyc = c;
         if (obs_ack && ack_cyc < 0) begin
            ack_cyc   = c;
            bus.l_req = 1'b0;
         end
      end
      checkOutput("starve_stall_cycle", 32'(stall_cyc), 32'd5);
      checkOutput("starve_ack_cycle", 32'(ack_cyc), 32'd6);

      // Loader write contending with a pipeline store.
      bus.p_req   = 1'b1;
      bus.p_addr  = 32'h100;
      bus.p_wdata = 32'h11112222;
      bus.p_we    = 4'b1111;
      bus.l_req   = 1'b1;
      bus.l_addr  = 32'h80;
      bus.l_wdata = 32'h0000ABCD;
      bus.l_we    = 4'b0011;
      saw_stall   = 1'b0;
      prev_stall  = 1'b0;
      for (int c = 0; c < 12; c++) begin
         applyStimulus();
         if (prev_stall) begin
            checkOutput("wr_after_we", 32'(obs_we), 32'hF);
            checkOutput("wr_after_daddr", obs_daddr, 32'h100);
         end
         if (obs_stall) begin
            saw_stall = 1'b1;
            checkOutput("wr_acc_we", 32'(obs_we), 32'h3);
            checkOutput("wr_acc_daddr", obs_daddr, 32'h80);
            checkOutput("wr_acc_dwdata", obs_dwdata, 32'h0000ABCD);
         end
         prev_stall = obs_stall;
         if (obs_ack) bus.l_req = 1'b0;
      end
      checkOutput("wr_granted", 32'(saw_stall), 32'd1);
      checkOutput("wr_mem", 32'(mem[32][15:0]), 32'hABCD);

      // Reset landing on the access cycle of a loader write.
      bus.p_req   = 1'b0;
      bus.p_we    = 4'b0000;
      bus.p_addr  = 32'h20;
      bus.l_req   = 1'b1;
      bus.l_addr  = 32'hC0;
      bus.l_wdata = 32'hFFFFFFFF;
      bus.l_we    = 4'b1111;
      applyStimulus();
      reset = 1'b1;
      applyStimulus();
      checkOutput("rst_acc_we", 32'(obs_we), 32'd0);
      reset     = 1'b0;
      bus.l_req = 1'b0;
      applyStimulus();
      checkOutput("rst_no_ack", 32'(obs_ack), 32'd0);
      checkOutput("rst_arb_daddr", obs_daddr, 32'h20);
      checkOutput("rst_mem_kept", mem[48], 32'h5A5A5A5A);

`ifdef DMEM_ARB_STATS_EN
      reset = 1'b1;
      applyStimulus();
      reset       = 1'b0;
      bus.p_req   = 1'b1;
      bus.p_we    = 4'b0000;
      bus.l_req   = 1'b1;
      bus.l_we    = 4'b0000;
      acks        = 0;
      for (int c = 0; c < 60 && acks < 3; c++) begin
         applyStimulus();
         if (obs_ack) acks++;
      end
      bus.l_req = 1'b0;
      applyStimulus();
      checkOutput("stats_acks", 32'(acks), 32'd3);
      checkOutput("stats_grant", 32'(grant_count), 32'd3);
      checkOutput("stats_stall", 32'(stall_count), 32'd3);
`else
      acks = 0;
`endif

      // Randomized traffic.
      bus.l_req = 1'b0;
      for (int i = 0; i < 500; i++) begin
         reset = ($urandom_range(0, 59) == 0);
         if (!obs_stall) begin
            bus.p_req   = ($urandom_range(0, 3) != 0);
            bus.p_addr  = 32'($urandom_range(0, 255)) << 2;
            bus.p_wdata = $urandom;
            bus.p_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
         end
         if (bus.l_req) begin
            if (obs_ack) begin
               if ($urandom_range(0, 3) == 0) newLoaderRequest();
               else bus.l_req = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
               bus.l_req = 1'b0;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            newLoaderRequest();
         end
         applyStimulus();
      end

`ifdef DMEM_ARB_STATS_EN
      checkOutput("rand_grant_count", 32'(grant_count), 32'(m_grants));
      checkOutput("rand_stall_count", 32'(stall_count), 32'(m_stalls));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
